// File: rtl/register_file_arbiter.sv
// register_file_arbiter
//   Shares one asynchronous register_file between NumReq requesters. Requests are arbitrated
//   round-robin. The controller sequences chip-select, write-strobe and output-enable itself and
//   owns the tristate data bus, so requesters only see a req/gnt/done handshake.
//
//   Transaction timeline, in cycles after the accepting edge:
//     cycle 0  gnt_o[k] pulse, operands latched
//     cycle 1  SETUP   : cs_n=0, address valid, write data driven (write) or oe=1 (read)
//     cycle 2  STROBE  : ws=1 (write commits on its rising edge) / read data sampled at the end
//     cycle 3  RELEASE : ws=0, oe=0, cs_n and address held, done_o[k] pulse
//   The next grant can appear in cycle 4.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_i, we_i         per-requester request level and write select
//   addr_i, wdata_i     packed per-requester address and write data
//   gnt_o, done_o       one-hot single-cycle accept / complete pulses
//   rdata_o             data from the most recent read
//   busy_o              a transaction is in progress (cycles 0..3)
//   rf_*                register_file strobes, address and tristate data bus
module register_file_arbiter #(
    parameter int unsigned Width  = 8,
    parameter int unsigned Depth  = 5,
    parameter int unsigned NumReq = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumReq-1:0]         req_i,
    input  logic [NumReq-1:0]         we_i,
    input  logic [NumReq*Depth-1:0]   addr_i,
    input  logic [NumReq*Width-1:0]   wdata_i,
    output logic [NumReq-1:0]         gnt_o,
    output logic [NumReq-1:0]         done_o,
    output logic [Width-1:0]          rdata_o,
    output logic                      busy_o,
    output logic                      rf_cs_no,
    output logic                      rf_ws_o,
    output logic                      rf_oe_o,
    output logic [Depth-1:0]          rf_address_o,
    inout  wire  [Width-1:0]          rf_data_io
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    // state_q names the phase whose registered outputs are produced at the next edge, so the
    // visible phase lags state_q by one cycle.
    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StRelease
    } state_e;

    state_e            state_q;
    logic [IdxW-1:0]   ptr_q;
    logic [IdxW-1:0]   sel_q;
    logic              we_q;
    logic [Depth-1:0]  addr_q;
    logic [Width-1:0]  wdata_q;
    logic              drive_q;

    logic              found;
    logic [IdxW-1:0]   pick;
    logic [IdxW-1:0]   ptr_next;
    int unsigned       cand;

    // First asserted request at or after the round-robin pointer, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            if (!found && req_i[cand]) begin
                found = 1'b1;
                pick  = IdxW'(cand);
            end
        end
    end

    always_comb begin
        if (32'(pick) == NumReq - 1) begin
            ptr_next = '0;
        end else begin
            ptr_next = pick + 1'b1;
        end
    end

    // The bus is driven through SETUP, STROBE and RELEASE of a write only; oe is never set then.
    assign rf_data_io = drive_q ? wdata_q : {Width{1'bz}};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            drive_q      <= 1'b0;
            gnt_o        <= '0;
            done_o       <= '0;
            rdata_o      <= '0;
            busy_o       <= 1'b0;
            rf_cs_no     <= 1'b1;
            rf_ws_o      <= 1'b0;
            rf_oe_o      <= 1'b0;
            rf_address_o <= '0;
        end else begin
            gnt_o  <= '0;
            done_o <= '0;
            unique case (state_q)
                StIdle: begin
                    rf_cs_no <= 1'b1;
                    rf_ws_o  <= 1'b0;
                    rf_oe_o  <= 1'b0;
                    drive_q  <= 1'b0;
                    busy_o   <= 1'b0;
                    if (found) begin
                        gnt_o   <= NumReq'(1) << pick;
                        sel_q   <= pick;
                        we_q    <= we_i[pick];
                        addr_q  <= addr_i[32'(pick)*Depth +: Depth];
                        wdata_q <= wdata_i[32'(pick)*Width +: Width];
                        ptr_q   <= ptr_next;
                        busy_o  <= 1'b1;
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    rf_cs_no     <= 1'b0;
                    rf_address_o <= addr_q;
                    rf_ws_o      <= 1'b0;
                    drive_q      <= we_q;
                    rf_oe_o      <= ~we_q;
                    state_q      <= StStrobe;
                end
                StStrobe: begin
                    rf_ws_o <= we_q;
                    state_q <= StRelease;
                end
                StRelease: begin
                    rf_ws_o <= 1'b0;
                    rf_oe_o <= 1'b0;
                    done_o  <= NumReq'(1) << sel_q;
                    // oe has been high for the whole visible STROBE cycle that ends here.
                    if (!we_q) begin
                        rdata_o <= rf_data_io;
                    end
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
